ifetch: RTL

Instruction fetch stage, directly upstream of the instruction decoder. Holds the program counter and issues one word read at a time on the instruction-read bus (address and data channels, each valid/ready). Each returned word is presented with its PC on a valid/ready output that feeds the decoder's `inst` input. Execute-stage redirects (taken branch, JAL) flush any in-flight or buffered instruction and restart fetch at the new target.

---
 rtl/ifetch_pkg.sv | 15 +
 rtl/ifetch.sv | 114 +++++++++++
 2 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, FSM state encoding and word-alignment helper for the fetch stage.
package ifetch_pkg;
    localparam int PC_WIDTH   = 32;
    localparam int INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IFETCH_REQ  = 2'd0,
        IFETCH_WAIT = 2'd1,
        IFETCH_FULL = 2'd2
    } ifetch_state_e;

    function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
        return {a[PC_WIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding word read, a 1-entry output buffer to the
// decoder, and redirect handling that flushes in-flight or buffered instructions.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] PC_INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [PC_WIDTH-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [INST_WIDTH-1:0] ir_data,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc
);
    ifetch_state_e         r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc, r_req_addr, r_inst_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_kill;
    logic [PC_WIDTH-1:0]   w_target;

    assign w_target = word_align(redirect_pc);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IFETCH_REQ;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IFETCH_REQ:  if (ir_addr_ready) w_state_nxt = IFETCH_WAIT;
            IFETCH_WAIT: if (ir_data_valid)
                             w_state_nxt = (redirect_valid || r_kill) ? IFETCH_REQ : IFETCH_FULL;
            IFETCH_FULL: if (redirect_valid || inst_ready) w_state_nxt = IFETCH_REQ;
            default:     w_state_nxt = IFETCH_REQ;
        endcase
    end

    // Handshake strobes are masked during reset so a stale bus response is never taken.
    always_comb begin
        ir_addr_valid = 1'b0;
        ir_data_ready = 1'b0;
        inst_valid    = 1'b0;
        if (!rst) begin
            case (r_state)
                IFETCH_REQ:  ir_addr_valid = 1'b1;
                IFETCH_WAIT: ir_data_ready = 1'b1;
                IFETCH_FULL: inst_valid    = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= PC_INIT;
            r_req_addr <= PC_INIT;
            r_kill     <= 1'b0;
            r_inst     <= '0;
            r_inst_pc  <= '0;
        end else begin
            case (r_state)
                IFETCH_REQ: begin
                    if (ir_addr_ready) begin
                        // A redirect racing the accept leaves a stale read in flight.
                        r_pc   <= redirect_valid ? w_target : r_req_addr + PC_WIDTH'(4);
                        r_kill <= redirect_valid;
                    end else if (redirect_valid) begin
                        r_req_addr <= w_target;
                        r_pc       <= w_target;
                    end
                end
                IFETCH_WAIT: begin
                    if (ir_data_valid) begin
                        r_kill <= 1'b0;
                        if (redirect_valid) begin
                            r_req_addr <= w_target;
                            r_pc       <= w_target;
                        end else if (r_kill) begin
                            r_req_addr <= r_pc;
                        end else begin
                            r_inst    <= ir_data;
                            r_inst_pc <= r_req_addr;
                        end
                    end else if (redirect_valid) begin
                        r_kill <= 1'b1;
                        r_pc   <= w_target;
                    end
                end
                IFETCH_FULL: begin
                    if (redirect_valid) begin
                        r_req_addr <= w_target;
                        r_pc       <= w_target;
                    end else if (inst_ready) begin
                        r_req_addr <= r_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir_addr = r_req_addr;
    assign inst    = r_inst;
    assign inst_pc = r_inst_pc;
endmodule
